// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter.
package cdb_pkg;

    localparam int unsigned CDB_PORTS = 4;
    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned DATA_W    = 32;

    localparam logic [ROB_TAG_W-1:0] NULL_TAG = '0;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    value;
        logic                 isjump;
        logic [DATA_W-1:0]    jump_addr;
    } cdb_entry_t;

    function automatic logic [1:0] onehot_to_idx(input logic [CDB_PORTS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < CDB_PORTS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side request bus and CDB broadcast outputs of the arbiter.
interface cdb_arbiter_if;

    logic [cdb_pkg::CDB_PORTS-1:0]                    req_valid;
    logic [cdb_pkg::CDB_PORTS*cdb_pkg::ROB_TAG_W-1:0] req_tag;
    logic [cdb_pkg::CDB_PORTS*cdb_pkg::DATA_W-1:0]    req_value;
    logic [cdb_pkg::CDB_PORTS-1:0]                    req_isjump;
    logic [cdb_pkg::CDB_PORTS*cdb_pkg::DATA_W-1:0]    req_jump_addr;
    logic [cdb_pkg::CDB_PORTS-1:0]                    req_ready;

    logic [cdb_pkg::ROB_TAG_W-1:0] out_cdb_rob_tag;
    logic [cdb_pkg::DATA_W-1:0]    out_cdb_value;
    logic                          out_cdb_isjump;
    logic [cdb_pkg::DATA_W-1:0]    out_cdb_jump_addr;

    modport master (
        output req_valid, req_tag, req_value, req_isjump, req_jump_addr,
        input  req_ready,
        input  out_cdb_rob_tag, out_cdb_value, out_cdb_isjump, out_cdb_jump_addr
    );

    modport slave (
        input  req_valid, req_tag, req_value, req_isjump, req_jump_addr,
        output req_ready,
        output out_cdb_rob_tag, out_cdb_value, out_cdb_isjump, out_cdb_jump_addr
    );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin picker: first request at or above ptr_i, wrapping.
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] grant_o,
    output logic       valid_o
);

    logic [1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_i + 2'(k);
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// One-slot-per-port result buffer with a round-robin grant onto a registered CDB.
// CDB_BYPASS_EN: when all slots are empty, the winning incoming request goes straight out.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_flush,
    cdb_arbiter_if.slave bus
);

    cdb_entry_t           slot_q [CDB_PORTS];
    cdb_entry_t           slot_d [CDB_PORTS];
    logic [CDB_PORTS-1:0] occ_q, occ_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    cdb_entry_t           out_q, out_d;

    cdb_entry_t           req_ent [CDB_PORTS];
    logic [CDB_PORTS-1:0] req_live;
    logic [CDB_PORTS-1:0] arb_req;
    logic [CDB_PORTS-1:0] grant_oh;
    logic                 grant_valid;
    logic [1:0]           grant_idx;
    logic                 bypass;

    always_comb begin
        for (int i = 0; i < CDB_PORTS; i++) begin
            req_ent[i].tag       = bus.req_tag[ROB_TAG_W*i +: ROB_TAG_W];
            req_ent[i].value     = bus.req_value[DATA_W*i +: DATA_W];
            req_ent[i].isjump    = bus.req_isjump[i];
            req_ent[i].jump_addr = bus.req_jump_addr[DATA_W*i +: DATA_W];
            req_live[i]          = bus.req_valid[i] && (req_ent[i].tag != NULL_TAG);
        end
    end

`ifdef CDB_BYPASS_EN
    assign bypass = (occ_q == '0);
`else
    assign bypass = 1'b0;
`endif

    // In bypass the arbiter races the incoming requests instead of the (empty) slots.
    assign arb_req = bypass ? req_live : occ_q;

    rr_arbiter4 u_rr (
        .req_i   (arb_req),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_oh),
        .valid_o (grant_valid)
    );

    assign grant_idx     = onehot_to_idx(grant_oh);
    assign bus.req_ready = rst ? '1 : (~occ_q | grant_oh);

    always_comb begin
        slot_d   = slot_q;
        occ_d    = occ_q;
        rr_ptr_d = rr_ptr_q;
        out_d    = '0;
        if (rst) begin
            occ_d    = '0;
            rr_ptr_d = '0;
            for (int i = 0; i < CDB_PORTS; i++) slot_d[i] = '0;
        end else if (in_flush) begin
            occ_d = '0;
        end else begin
            if (grant_valid) begin
                rr_ptr_d = grant_idx + 2'd1;
                if (bypass) begin
                    out_d = req_ent[grant_idx];
                end else begin
                    out_d            = slot_q[grant_idx];
                    occ_d[grant_idx] = 1'b0;
                end
            end
            // A bypassed winner is already on its way out, so it is not also captured.
            for (int i = 0; i < CDB_PORTS; i++) begin
                if (req_live[i] && bus.req_ready[i] && !(bypass && grant_oh[i])) begin
                    occ_d[i]  = 1'b1;
                    slot_d[i] = req_ent[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        slot_q   <= slot_d;
        occ_q    <= occ_d;
        rr_ptr_q <= rr_ptr_d;
        out_q    <= out_d;
    end

    assign bus.out_cdb_rob_tag   = out_q.tag;
    assign bus.out_cdb_value     = out_q.value;
    assign bus.out_cdb_isjump    = out_q.isjump;
    assign bus.out_cdb_jump_addr = out_q.jump_addr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a slot/pointer reference model predicts each broadcast.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic in_flush;
    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .in_flush (in_flush),
        .bus      (bus)
    );

    typedef struct {
        int         cyc;
        cdb_entry_t ent;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    // Reference model state: what each port's slot holds and where the search starts.
    bit         m_occ  [4];
    cdb_entry_t m_slot [4];
    int         m_ptr;

    logic [3:0] v_valid;
    cdb_entry_t v_ent [4];

    bit trk = 1'b0;
    int run = 0;
    int max_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            cdb_entry_t e;
            cdb_entry_t a;
            e = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL cdb_stale cyc=%0d expected tag %0h at cyc %0d never seen",
                         cyc, exp_q[0].ent.tag, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front().ent;
            a = {bus.out_cdb_rob_tag, bus.out_cdb_value, bus.out_cdb_isjump,
                 bus.out_cdb_jump_addr};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL cdb_out cyc=%0d got tag=%0h val=%h j=%b ja=%h want tag=%0h val=%h j=%b ja=%h",
                         cyc, a.tag, a.value, a.isjump, a.jump_addr,
                         e.tag, e.value, e.isjump, e.jump_addr);
            end
        end
    end

    function automatic cdb_entry_t rand_ent(input logic [3:0] tag);
        cdb_entry_t e;
        e.tag       = tag;
        e.value     = $urandom;
        e.isjump    = 1'($urandom_range(0, 1));
        e.jump_addr = $urandom;
        return e;
    endfunction

    task automatic clear_reqs();
        v_valid = '0;
        for (int i = 0; i < 4; i++) v_ent[i] = rand_ent(4'($urandom_range(0, 15)));
    endtask

    task automatic set_req(input int p, input logic [3:0] tag);
        v_valid[p] = 1'b1;
        v_ent[p]   = rand_ent(tag);
    endtask

    // Drive one cycle's inputs, check ready, advance the model, predict the broadcast.
    task automatic step();
        int         win;
        int         idx;
        bit         byp;
        bit         any_occ;
        logic [3:0] exp_ready;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]             = v_valid[i];
            bus.req_tag[4*i +: 4]        = v_ent[i].tag;
            bus.req_value[32*i +: 32]    = v_ent[i].value;
            bus.req_isjump[i]            = v_ent[i].isjump;
            bus.req_jump_addr[32*i +: 32] = v_ent[i].jump_addr;
        end
        #1;
        win = -1;
        byp = 1'b0;
        any_occ = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (m_occ[idx]) any_occ = 1'b1;
            if (win < 0 && m_occ[idx]) win = idx;
        end
`ifdef CDB_BYPASS_EN
        if (!any_occ) begin
            byp = 1'b1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (win < 0 && v_valid[idx] && v_ent[idx].tag != 4'd0) win = idx;
            end
        end
`endif
        for (int i = 0; i < 4; i++) exp_ready[i] = rst || !m_occ[i] || (i == win);
        n_cmp++;
        if (bus.req_ready !== exp_ready) begin
            n_err++;
            $display("FAIL req_ready cyc=%0d got %b want %b", cyc, bus.req_ready, exp_ready);
        end
        if (trk) begin
            if (!bus.req_ready[0]) run++;
            else run = 0;
            if (run > max_run) max_run = run;
        end
        if (rst) begin
            for (int i = 0; i < 4; i++) m_occ[i] = 1'b0;
            m_ptr = 0;
        end else if (in_flush) begin
            for (int i = 0; i < 4; i++) m_occ[i] = 1'b0;
        end else begin
            if (win >= 0) begin
                exp_t x;
                x.cyc = cyc + 1;
                x.ent = byp ? v_ent[win] : m_slot[win];
                exp_q.push_back(x);
                if (!byp) m_occ[win] = 1'b0;
                m_ptr = (win + 1) % 4;
            end
            for (int i = 0; i < 4; i++) begin
                if (v_valid[i] && v_ent[i].tag != 4'd0 && exp_ready[i] && !(byp && i == win)) begin
                    m_occ[i]  = 1'b1;
                    m_slot[i] = v_ent[i];
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        clear_reqs();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        in_flush = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            m_occ[i]  = 1'b0;
            m_slot[i] = '0;
        end
        clear_reqs();
        mon_en = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Single request, value 0x2A.
        set_req(0, 4'd3);
        v_ent[0].value = 32'h2A;
        step();
        idle(4);

        // Four-way contention, twice to show the pointer wraps back to 0.
        for (int r = 0; r < 2; r++) begin
            clear_reqs();
            for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1));
            step();
            idle(6);
        end

        // Port 0 streams while port 2 presents once.
        trk = 1'b1;
        for (int c = 0; c < 12; c++) begin
            clear_reqs();
            set_req(0, 4'd5);
            if (c == 2) set_req(2, 4'd7);
            step();
        end
        trk = 1'b0;
        n_cmp++;
        if (max_run > 1) begin
            n_err++;
            $display("FAIL ready0_stall got %0d cycles want <= 1", max_run);
        end
        idle(6);

        // Flush with two slots held plus a new request.
        clear_reqs();
        set_req(0, 4'd1);
        set_req(1, 4'd2);
        step();
        clear_reqs();
        set_req(2, 4'd6);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        idle(1);
        n_cmp++;
        if (bus.req_ready !== 4'b1111) begin
            n_err++;
            $display("FAIL flush_ready got %b want 1111", bus.req_ready);
        end
        idle(3);

        // Null tag, then reset with three slots full, then contention from pointer 0.
        clear_reqs();
        set_req(0, 4'd0);
        step();
        idle(3);
        clear_reqs();
        set_req(1, 4'd9);
        set_req(2, 4'd10);
        set_req(3, 4'd11);
        step();
        clear_reqs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_reqs();
        for (int i = 0; i < 4; i++) set_req(i, 4'(i + 12 - 8));
        step();
        idle(6);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 400; c++) begin
            clear_reqs();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 1) set_req(i, 4'($urandom_range(0, 15)));
            end
            in_flush = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            step();
        end
        in_flush = 1'b0;
        rst = 1'b0;
        idle(8);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have `clk`, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: reset, synchronous, active-high; clock `clk`.
REQ-003 SHALL have `in_flush`, input, 1 bit: misbranch flush, taken from the ROB misbranch output.
REQ-004 SHALL have `req_valid`, input, 4 bits: per-port result valid; port 0 ALU, 1 branch, 2 load, 3 spare.
REQ-005 SHALL have `req_tag`, input, 16 bits: 4-bit ROB tag per port; port i uses bits [4i+3:4i].
REQ-006 SHALL have `req_value`, input, 128 bits: 32-bit result per port.
REQ-007 SHALL have `req_isjump`, input, 4 bits: per-port branch-taken flag.
REQ-008 SHALL have `req_jump_addr`, input, 128 bits: 32-bit jump target per port.
REQ-009 SHALL have `req_ready`, output, 4 bits: per-port slot can accept a request this cycle.
REQ-010 SHALL have `out_cdb_rob_tag`, output, 4 bits: broadcast tag; 0 means no broadcast.
REQ-011 SHALL have `out_cdb_value`, output, 32 bits: broadcast result.
REQ-012 SHALL have `out_cdb_isjump`, output, 1 bit: broadcast jump flag.
REQ-013 SHALL have `out_cdb_jump_addr`, output, 32 bits: broadcast jump target.

Function
REQ-014 SHALL hold one slot per port (occupied bit, tag, value, isjump, jump_addr).
REQ-015 SHALL accept a request on a rising edge when req_valid[i] and req_ready[i] are both 1.
REQ-016 SHALL silently drop a valid request whose tag is 0, leaving the slot empty.
REQ-017 SHALL drive req_ready[i] = slot i empty OR slot i granted this cycle, so a port sustains one result per cycle.
REQ-018 SHALL grant at most one occupied slot per cycle, round-robin, searching from rr_ptr upward modulo 4.
REQ-019 SHALL load the granted slot into the registered outputs and clear that slot on the same edge.
REQ-020 SHALL set rr_ptr to (granted index + 1) mod 4 after a grant, and leave it unchanged when there is no grant.
REQ-021 SHALL drive all four outputs to 0 on any cycle following an edge with no grant; outputs are registered and held for exactly one cycle.
REQ-022 Base latency SHALL be 2 edges: captured at edge N, broadcast visible after edge N+1.
REQ-023 When a port is full and not granted, SHALL hold req_ready low and keep slot contents unchanged.
REQ-024 On in_flush = 1, SHALL at the next edge clear all slots, drop all requests presented that cycle, zero all outputs and keep rr_ptr.
REQ-025 When in_flush and a grant coincide, flush SHALL win and no broadcast SHALL occur.

Reset
REQ-026 On rst = 1 at an edge, SHALL clear all slots, set rr_ptr = 0 and zero all outputs.
REQ-027 During reset, req_ready SHALL read 4'b1111 and incoming requests SHALL be dropped.
REQ-028 Reset asserted mid-operation SHALL discard all pending results; rst has priority over in_flush.

Configuration
REQ-029 With CDB_BYPASS_EN defined, when all slots are empty the block SHALL round-robin among incoming valid nonzero-tag requests, send the winner straight to the outputs (1-edge latency), capture the losers into their slots, and update rr_ptr as for a grant.
REQ-030 With CDB_BYPASS_EN undefined, every result SHALL pass through its slot (2-edge latency).

Structure
REQ-031 Package cdb_pkg SHALL define CDB_PORTS = 4, ROB_TAG_W = 4, DATA_W = 32, NULL_TAG = 0 and a packed struct cdb_entry_t {tag, value, isjump, jump_addr}.
REQ-032 SHALL instantiate one sub-module, rr_arbiter4 (request vector and pointer in, one-hot grant and valid out, combinational).

Verification
REQ-033 Single request: port 0, tag 3, value 0x2A, after reset -> tag 3, value 0x2A at edge 2 (edge 1 with CDB_BYPASS_EN), then tag 0.
REQ-034 Contention: ports 0-3 fire tags 1-4 together with rr_ptr = 0 -> broadcasts tags 1, 2, 3, 4 on four consecutive cycles; rr_ptr ends at 0.
REQ-035 Fairness: port 0 streams tags 5 every cycle and port 2 presents tag 7 once -> tag 7 is broadcast within 2 grants; req_ready[0] never stalls longer than 1 cycle.
REQ-036 Flush: slots hold tags 1 and 2, and in_flush is pulsed together with a new tag 6 -> no broadcast of 1, 2 or 6; outputs are 0; req_ready = 4'b1111.
REQ-037 Null and reset: tag 0 request -> no broadcast; rst asserted with 3 slots full -> outputs 0 and rr_ptr = 0 on the next cycle.
